// File: rtl/cache_cfg_pkg.sv
// Shared configuration for the cache associativity mode controller:
// mode encodings, way enable masks and the controller state set.
package cache_cfg_pkg;

    localparam int DEF_WAYS    = 8;
    localparam int DEF_INDEX_W = 12;
    localparam int WAY_W       = 3;

    localparam logic [1:0] MODE_DM = 2'b00;
    localparam logic [1:0] MODE_2W = 2'b01;
    localparam logic [1:0] MODE_4W = 2'b10;
    localparam logic [1:0] MODE_8W = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_READ,
        ST_CHECK,
        ST_WB,
        ST_INV,
        ST_COMMIT
    } state_t;

    // Ways enabled by a mode; way n sits at bit (WAYS-1-n), so enabled
    // ways fill the mask from the MSB down (DM -> 1000_0000).
    function automatic logic [DEF_WAYS-1:0] way_mask(input logic [1:0] mode);
        logic [DEF_WAYS-1:0] m;
        int                  n_en;
        m    = '0;
        n_en = 1 << mode;
        for (int i = 0; i < DEF_WAYS; i++) begin
            if (i < n_en) m[DEF_WAYS-1-i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cache_way_pick.sv
// Finds the lowest-numbered way set in a dirty vector. Way n lives at
// bit (WAYS-1-n), so the lowest-numbered way is the highest set bit.
module cache_way_pick
    import cache_cfg_pkg::*;
#(
    parameter int WAYS = DEF_WAYS
) (
    input  logic [WAYS-1:0]  vec,
    output logic [WAY_W-1:0] way,
    output logic             found
);

    // Scan from the highest way number down so the lowest one wins.
    always_comb begin
        way   = '0;
        found = 1'b0;
        for (int n = WAYS - 1; n >= 0; n--) begin
            if (vec[WAYS-1-n]) begin
                way   = WAY_W'(n);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mode_ctrl.sv
// Sequences a cache associativity mode change: stall the CPU, drain the
// in-flight access, then sweep every index writing back dirty lines of the
// ways enabled under the old mode and invalidating all ways, and finally
// commit the new mode.
module cache_mode_ctrl
    import cache_cfg_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WAYS    = DEF_WAYS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_req,
    input  logic [1:0]         mode_new,
    output logic               mode_ack,
    input  logic               cpu_busy,
    output logic               stall,
    output logic [1:0]         sel,
    output logic [INDEX_W-1:0] sweep_index,
    input  logic [WAYS-1:0]    dirty_vec,
    output logic               wb_req,
    output logic [WAY_W-1:0]   wb_way,
    input  logic               wb_ack,
    output logic               inv_en
);

    localparam logic [INDEX_W-1:0] LAST_IDX = '1;

    state_t             state, state_d;
    logic [1:0]         pend;
    logic [INDEX_W-1:0] idx;
    logic [WAYS-1:0]    pending;
    logic               gap;       // one idle cycle after each wb_ack

    logic [WAYS-1:0]    mask;
    logic [WAY_W-1:0]   pick_way;
    logic               pick_found;
    logic [WAYS-1:0]    pick_bit;

    // Old-mode mask: sel only changes on the commit edge, so during the
    // sweep it still describes which ways may hold valid dirty data.
    assign mask        = way_mask(sel);
    assign sweep_index = idx;
    assign pick_bit    = {{(WAYS-1){1'b0}}, 1'b1} << (WAYS - 1 - int'(pick_way));

    cache_way_pick #(.WAYS(WAYS)) u_pick (
        .vec   (pending),
        .way   (pick_way),
        .found (pick_found)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_d  = state;
        stall    = 1'b1;
        mode_ack = 1'b0;
        wb_req   = 1'b0;
        wb_way   = '0;
        inv_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = 1'b0;
                if (mode_req) state_d = (mode_new == sel) ? ST_COMMIT : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!cpu_busy) state_d = ST_READ;
            end
            ST_READ: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = ((dirty_vec & mask) != '0) ? ST_WB : ST_INV;
            end
            ST_WB: begin
                wb_way = pick_way;
                wb_req = !gap && pick_found;
                if (!pick_found)
                    state_d = ST_INV;
                else if (!gap && wb_ack && ((pending & ~pick_bit) == '0))
                    state_d = ST_INV;
            end
            ST_INV: begin
                inv_en  = 1'b1;
                state_d = (idx == LAST_IDX) ? ST_COMMIT : ST_READ;
            end
            ST_COMMIT: begin
                mode_ack = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sweep datapath: pending mode, index, per-index write-back set, and
    // the committed mode (updated on the edge that enters COMMIT).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel     <= MODE_DM;
            pend    <= MODE_DM;
            idx     <= '0;
            pending <= '0;
            gap     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mode_req) pend <= mode_new;
                end
                ST_DRAIN: begin
                    if (!cpu_busy) idx <= '0;
                end
                ST_CHECK: begin
                    pending <= dirty_vec & mask;
                    gap     <= 1'b0;
                end
                ST_WB: begin
                    if (gap) begin
                        gap <= 1'b0;
                    end else if (wb_ack && pick_found) begin
                        pending <= pending & ~pick_bit;
                        gap     <= 1'b1;
                    end
                end
                ST_INV: begin
                    if (idx != LAST_IDX) idx <= idx + INDEX_W'(1);
                    else                 sel <= pend;
                end
                ST_COMMIT: begin
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
